// File: rtl/dct_pkg.sv
// Shared widths, state encoding and address helper for the 8x8 transpose buffer.
// Optional feature macro: TCTRL_CLR_EN adds a one-cycle CLEAR state that pulses ram_clr.
package dct_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DCT_N  = 8;
    localparam int unsigned IDX_W  = $clog2(DCT_N);

`ifdef TCTRL_CLR_EN
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } tctrl_state_e;

    // State entered after reset, flush and block completion
    localparam tctrl_state_e ST_ENTRY = ST_CLEAR;
`else
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } tctrl_state_e;

    localparam tctrl_state_e ST_ENTRY = ST_FILL;
`endif

    // Linear read index -> {row, col} address so reads walk the block column by column
    function automatic logic [ADDR_W-1:0] col_major_addr(input logic [ADDR_W-1:0] idx);
        return {idx[IDX_W-1:0], idx[ADDR_W-1:IDX_W]};
    endfunction

endpackage

// File: rtl/idx_counter.sv
// Wrapping block index counter with synchronous flush and a wrap flag on the last count.
module idx_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_en,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap_c
);

    logic [WIDTH-1:0] r_count;

    // Count enabled events; flush returns to zero ahead of any increment
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count  = r_count;
    assign o_wrap_c = i_en && !i_flush && (r_count == {WIDTH{1'b1}});

endmodule

// File: rtl/transpose_ctrl.sv
// 8x8 transpose buffer controller between the row and column DCT stages.
// Rows are written into an external 64x16 RAM, then read back column-major into
// a one-deep output register. Define TCTRL_CLR_EN to add a one-cycle RAM clear
// state after reset, flush and each completed block.
module transpose_ctrl
    import dct_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    input  logic              flush,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] ram_data_in,
    output logic              ram_read,
    output logic              ram_write,
    output logic              ram_cs,
    output logic              ram_clr,
    input  logic [WORD_W-1:0] ram_data_out,
    output logic              block_done
);

    tctrl_state_e      r_state;
    tctrl_state_e      w_state_nxt;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              w_fill;
    logic              w_drain;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_wr_wrap;
    logic              w_rd_wrap;
    logic [ADDR_W-1:0] w_wcnt;
    logic [ADDR_W-1:0] w_rcnt;

    assign w_fill  = (r_state == ST_FILL);
    assign w_drain = (r_state == ST_DRAIN);

    // Flush withdraws ready so an offered sample is never silently dropped
    assign in_ready = w_fill && !flush;

    // Strobes are gated by clr_n so the RAM sees nothing while reset is held
    assign w_wr_en = clr_n && in_valid && in_ready;
    assign w_rd_en = clr_n && w_drain && !flush && (!r_out_valid || out_ready);

    idx_counter #(.WIDTH(ADDR_W)) u_wr_cnt (
        .clk      (clk),
        .clr_n    (clr_n),
        .i_en     (w_wr_en),
        .i_flush  (flush),
        .o_count  (w_wcnt),
        .o_wrap_c (w_wr_wrap)
    );

    idx_counter #(.WIDTH(ADDR_W)) u_rd_cnt (
        .clk      (clk),
        .clr_n    (clr_n),
        .i_en     (w_rd_en),
        .i_flush  (flush),
        .o_count  (w_rcnt),
        .o_wrap_c (w_rd_wrap)
    );

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_ENTRY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM strobes
    always_comb begin
        w_state_nxt = r_state;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        ram_clr     = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        block_done  = 1'b0;

        if (flush) begin
            w_state_nxt = ST_ENTRY;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_wr_en) begin
                        ram_write   = 1'b1;
                        ram_address = w_wcnt;
                        ram_data_in = in_data;
                    end
                    if (w_wr_wrap) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_rd_en) begin
                        ram_read    = 1'b1;
                        ram_address = col_major_addr(w_rcnt);
                    end
                    if (w_rd_wrap) begin
                        block_done  = 1'b1;
                        w_state_nxt = ST_ENTRY;
                    end
                end
`ifdef TCTRL_CLR_EN
                ST_CLEAR: begin
                    ram_clr     = clr_n;
                    w_state_nxt = ST_FILL;
                end
`endif
                default: begin
                    w_state_nxt = ST_ENTRY;
                end
            endcase
        end

        ram_cs = ram_read | ram_write;
    end

    // One-deep output register; a read issue reloads it, a consume with no reload empties it
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_rd_en) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ram_data_out;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
